// File: rtl/mm_sched_pkg.sv
// Shared types and constants for the matmul operand-read schedulers.
// Holds the D-read FSM state encoding, the default drain length and the N1 log2 helper.
package mm_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      CLEAR = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } d_sched_state_t;

   localparam int D_SCHED_DRAIN_DEFAULT = 2;

   function automatic int N1_LOG2(input int n1);
      return $clog2(n1);
   endfunction

endpackage

// File: rtl/d_sched_beat_cnt.sv
// Nested col/blk/row beat counter for the D-read scheduler.
// Advances on en, clears on clr, and flags the final beat of the job.
module d_sched_beat_cnt
   import mm_sched_pkg::*;
#(
   parameter int MW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [MW-1:0] col_max,
   input  logic [MW-1:0] blk_max,
   input  logic [MW-1:0] row_max,
   output logic          last
);

   logic [MW-1:0] col_q, col_d;
   logic [MW-1:0] blk_q, blk_d;
   logic [MW-1:0] row_q, row_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      col_d = col_q;
      blk_d = blk_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         blk_d = '0;
         row_d = '0;
      end else if (en) begin
         if (col_q == col_max) begin
            col_d = '0;
            if (blk_q == blk_max) begin
               blk_d = '0;
               row_d = (row_q == row_max) ? '0 : row_q + MW'(1);
            end else begin
               blk_d = blk_q + MW'(1);
            end
         end else begin
            col_d = col_q + MW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         blk_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         blk_q <= blk_d;
         row_q <= row_d;
      end
   end

   assign last = (col_q == col_max) && (blk_q == blk_max) && (row_q == row_max);

endmodule

// File: rtl/d_read_sched.sv
// Job sequencer for the D-operand read-address generator: validates a descriptor,
// clears the generator, streams valid_D beats, drains. Optional stall counter: D_SCHED_STALL_CNT_EN.
module d_read_sched
   import mm_sched_pkg::*;
#(
   parameter int N1           = 4,
   parameter int MATRIXSIZE_W = 16,
   parameter int DRAIN_CYC    = D_SCHED_DRAIN_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MATRIXSIZE_W-1:0] cfg_m1,
   input  logic [MATRIXSIZE_W-1:0] cfg_bw,
   input  logic [MATRIXSIZE_W-1:0] cfg_bn,
   input  logic                    dn_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err,
   output logic                    gen_rst,
   output logic                    valid_D,
   output logic [MATRIXSIZE_W-1:0] BLOCK_NUM,
   output logic [MATRIXSIZE_W-1:0] BLOCK_WIDTH,
   output logic [MATRIXSIZE_W-1:0] M1dN1,
   output logic [MATRIXSIZE_W-1:0] M1xBLOCK_WIDTHdN1
`ifdef D_SCHED_STALL_CNT_EN
   ,
   output logic [31:0]             stall_cnt
`endif
);

   localparam int MW = MATRIXSIZE_W;
   localparam int L  = N1_LOG2(N1);
   localparam int DW = $clog2(DRAIN_CYC + 2);

   d_sched_state_t state_q, state_d;
   logic [MW-1:0]  m1_q, m1_d;
   logic [MW-1:0]  bw_q, bw_d;
   logic [MW-1:0]  bn_q, bn_d;
   logic [MW-1:0]  m1dn1_q, m1dn1_d;
   logic [MW-1:0]  prod_q, prod_d;
   logic           cfg_err_q, cfg_err_d;
   logic [DW-1:0]  drain_q, drain_d;
`ifdef D_SCHED_STALL_CNT_EN
   logic [31:0]    stall_q, stall_d;
`endif

   logic [MW-1:0] m1dn1_c;
   logic          desc_bad;
   logic          beat_last;

   assign m1dn1_c  = m1_q >> L;
   assign desc_bad = (m1_q == '0) || (bw_q == '0) || (bn_q == '0) || (m1_q[L-1:0] != '0);

   always_comb begin
      state_d   = state_q;
      m1_d      = m1_q;
      bw_d      = bw_q;
      bn_d      = bn_q;
      m1dn1_d   = m1dn1_q;
      prod_d    = prod_q;
      cfg_err_d = cfg_err_q;
      drain_d   = drain_q;
`ifdef D_SCHED_STALL_CNT_EN
      stall_d   = stall_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               m1_d      = cfg_m1;
               bw_d      = cfg_bw;
               bn_d      = cfg_bn;
               cfg_err_d = 1'b0;
`ifdef D_SCHED_STALL_CNT_EN
               stall_d   = '0;
`endif
               state_d   = CHECK;
            end
         end
         CHECK: begin
            m1dn1_d = m1dn1_c;
            prod_d  = m1dn1_c * bw_q;
            if (desc_bad) begin
               cfg_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               state_d   = CLEAR;
            end
         end
         CLEAR: state_d = RUN;
         RUN: begin
`ifdef D_SCHED_STALL_CNT_EN
            if (!dn_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
`endif
            if (dn_ready && beat_last) begin
               drain_d = DW'(DRAIN_CYC);
               state_d = DRAIN;
            end
         end
         // One cycle for the generator's output register, then DRAIN_CYC settle cycles.
         DRAIN: begin
            if (drain_q == '0) state_d = DONE;
            else               drain_d = drain_q - DW'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         m1_q      <= '0;
         bw_q      <= '0;
         bn_q      <= '0;
         m1dn1_q   <= '0;
         prod_q    <= '0;
         cfg_err_q <= 1'b0;
         drain_q   <= '0;
`ifdef D_SCHED_STALL_CNT_EN
         stall_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         m1_q      <= m1_d;
         bw_q      <= bw_d;
         bn_q      <= bn_d;
         m1dn1_q   <= m1dn1_d;
         prod_q    <= prod_d;
         cfg_err_q <= cfg_err_d;
         drain_q   <= drain_d;
`ifdef D_SCHED_STALL_CNT_EN
         stall_q   <= stall_d;
`endif
      end
   end

   d_sched_beat_cnt #(.MW(MW)) u_beat_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == CLEAR),
      .en      (valid_D),
      .col_max (bw_q - MW'(1)),
      .blk_max (bn_q - MW'(1)),
      .row_max (m1_q - MW'(1)),
      .last    (beat_last)
   );

   // valid_D is purely combinational so an async reset kills the beat in the same cycle.
   assign valid_D           = (state_q == RUN) && dn_ready;
   assign busy              = (state_q != IDLE);
   assign done              = (state_q == DONE);
   assign gen_rst           = (state_q == IDLE) || (state_q == CHECK) || (state_q == CLEAR);
   assign cfg_err           = cfg_err_q;
   assign BLOCK_NUM         = bn_q;
   assign BLOCK_WIDTH       = bw_q;
   assign M1dN1             = m1dn1_q;
   assign M1xBLOCK_WIDTHdN1 = prod_q;
`ifdef D_SCHED_STALL_CNT_EN
   assign stall_cnt         = stall_q;
`endif

endmodule

// File: tb/tb_d_read_sched.sv
// Scoreboard bench for d_read_sched: each job pushes hand-computed expectations,
// a negedge monitor pops and compares them on every done pulse.
`timescale 1ns/1ps
module tb_d_read_sched;

   localparam int MW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [MW-1:0] cfg_m1, cfg_bw, cfg_bn;
   logic          dn_ready;
   logic          busy, done, cfg_err, gen_rst, valid_D;
   logic [MW-1:0] BLOCK_NUM, BLOCK_WIDTH, M1dN1, M1xBLOCK_WIDTHdN1;
`ifdef D_SCHED_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   d_read_sched #(.N1(4), .MATRIXSIZE_W(MW), .DRAIN_CYC(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .cfg_m1            (cfg_m1),
      .cfg_bw            (cfg_bw),
      .cfg_bn            (cfg_bn),
      .dn_ready          (dn_ready),
      .busy              (busy),
      .done              (done),
      .cfg_err           (cfg_err),
      .gen_rst           (gen_rst),
      .valid_D           (valid_D),
      .BLOCK_NUM         (BLOCK_NUM),
      .BLOCK_WIDTH       (BLOCK_WIDTH),
      .M1dN1             (M1dN1),
      .M1xBLOCK_WIDTHdN1 (M1xBLOCK_WIDTHdN1)
`ifdef D_SCHED_STALL_CNT_EN
      ,
      .stall_cnt         (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Fields: error flag, beat count, M1dN1, product, BLOCK_NUM, BLOCK_WIDTH,
   // done cycle (offset from start cycle, made absolute on push), last-beat-to-done, beat span, stalls.
   typedef struct {
      bit err;
      int beats;
      int m1dn1;
      int prod;
      int bn;
      int bw;
      int done_cyc;
      int lat;
      int span;
      int stall;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor
   int   beats   = 0;
   int   first_c = 0;
   int   last_c  = 0;
   exp_t em;

   always @(negedge clk) begin
      if (rst) begin
         beats = 0;
      end else begin
         if (valid_D) begin
            if (beats == 0) first_c = cyc;
            last_c = cyc;
            beats++;
         end
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               em = q.pop_front();
               check("done_cycle", cyc, em.done_cyc);
               check("cfg_err", cfg_err, em.err);
               check("beats", beats, em.beats);
               check("M1dN1", M1dN1, em.m1dn1);
               check("M1xBLOCK_WIDTHdN1", M1xBLOCK_WIDTHdN1, em.prod);
               check("BLOCK_NUM", BLOCK_NUM, em.bn);
               check("BLOCK_WIDTH", BLOCK_WIDTH, em.bw);
               if (em.beats > 0) begin
                  check("last_beat_to_done", cyc - last_c, em.lat);
                  check("beat_span", last_c - first_c + 1, em.span);
               end
`ifdef D_SCHED_STALL_CNT_EN
               check("stall_cnt", stall_cnt, em.stall);
`endif
            end
            beats = 0;
         end
      end
   end

   // mode 0: dn_ready=1; mode 1: dn_ready low on the first RUN cycle, then toggling;
   // mode 2: dn_ready=1 and start held high until the cycle after the first done.
   task automatic run_job(input int m1, input int bw, input int bn, input int mode,
                          input exp_t e1, input exp_t e2, input int n_rec, input string tag);
      int cs;
      bit fin;
      exp_t e;
      @(posedge clk); #1;
      cs       = cyc;
      cfg_m1   = MW'(m1);
      cfg_bw   = MW'(bw);
      cfg_bn   = MW'(bn);
      start    = 1'b1;
      dn_ready = 1'b1;
      e = e1; e.done_cyc += cs; q.push_back(e);
      if (n_rec == 2) begin
         e = e2; e.done_cyc += cs; q.push_back(e);
      end
      fin = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         start    = (mode == 2) && (cyc <= cs + 11);
         dn_ready = (mode == 1) ? ((cyc - cs) % 2 == 0) : 1'b1;
         if (!start && !busy) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) check({tag, "_timeout"}, 0, 1);
   endtask

   exp_t none;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      none     = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      rst      = 1'b1;
      start    = 1'b0;
      dn_ready = 1'b0;
      cfg_m1   = '0;
      cfg_bw   = '0;
      cfg_bn   = '0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_valid_D", valid_D, 0);
      check("rst_gen_rst", gen_rst, 1);
      check("rst_cfg_outs", {BLOCK_NUM, BLOCK_WIDTH, M1dN1, M1xBLOCK_WIDTHdN1}, 0);
`ifdef D_SCHED_STALL_CNT_EN
      check("rst_stall_cnt", stall_cnt, 0);
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Nominal 8x4x2: 64 contiguous beats, RUN at cs+3..cs+66, done cs+70.
      run_job(8, 4, 2, 0, '{0, 64, 2, 8, 2, 4, 70, 4, 64, 0}, none, 1, "nominal");
      check("idle_gen_rst", gen_rst, 1);
      check("idle_hold_prod", M1xBLOCK_WIDTHdN1, 8);

      // Back-pressure: beats at cs+4,6..130, 128 RUN cycles, 64 stalls, done cs+134.
      run_job(8, 4, 2, 1, '{0, 64, 2, 8, 2, 4, 134, 4, 127, 64}, none, 1, "backpressure");

      // Illegal m1=6: DONE two cycles after start, M1dN1=1, product 1*4.
      run_job(6, 4, 2, 0, '{1, 0, 1, 4, 2, 4, 2, 0, 0, 0}, none, 1, "illegal");
      check("cfg_err_sticky", cfg_err, 1);

      // Legal m1=4 clears cfg_err: 24 beats, done cs+30.
      run_job(4, 2, 3, 0, '{0, 24, 1, 2, 3, 2, 30, 4, 24, 0}, none, 1, "clear_err");

      // Start held through a 4-beat job: one done at cs+10, re-accepted in IDLE at cs+11, done cs+21.
      run_job(4, 1, 1, 2, '{0, 4, 1, 1, 1, 1, 10, 4, 4, 0},
              '{0, 4, 1, 1, 1, 1, 21, 4, 4, 0}, 2, "busy_start");

      // Minimum job.
      run_job(4, 1, 1, 0, '{0, 4, 1, 1, 1, 1, 10, 4, 4, 0}, none, 1, "min_job");

      // Async reset in the middle of RUN: no done expected.
      @(posedge clk); #1;
      cfg_m1   = MW'(8);
      cfg_bw   = MW'(4);
      cfg_bn   = MW'(2);
      start    = 1'b1;
      dn_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("pre_rst_valid_D", valid_D, 1);
      #2 rst = 1'b1;
      #1;
      check("midrun_rst_valid_D", valid_D, 0);
      check("midrun_rst_gen_rst", gen_rst, 1);
      check("midrun_rst_busy", busy, 0);
      check("midrun_rst_done", done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_busy", busy, 0);
      check("queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
